// File: rtl/conv_wb_addr.sv
// Write-back address generator: steers each 2x2 conv output tile into the four banks of
// the destination SRAM group (conv1 -> group B, conv2 -> group A), one cycle after acceptance.
module conv_wb_addr #(
  parameter int C1_TILES = 6,
  parameter int C2_TILES = 5,
  parameter int C1_CH    = 4,
  parameter int C2_CH    = 8,
  parameter int ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        state,
  input  logic              conv_valid,
  input  logic [7:0]        conv_data0,
  input  logic [7:0]        conv_data1,
  input  logic [7:0]        conv_data2,
  input  logic [7:0]        conv_data3,
  output logic              sram_wen_a,
  output logic              sram_wen_b,
  output logic [3:0]        sram_wordmask_a,
  output logic [3:0]        sram_wordmask_b,
  output logic [ADDR_W-1:0] sram_waddr_a,
  output logic [ADDR_W-1:0] sram_waddr_b,
  output logic [31:0]       sram_wdata0,
  output logic [31:0]       sram_wdata1,
  output logic [31:0]       sram_wdata2,
  output logic [31:0]       sram_wdata3,
  output logic              layer_done
);

  localparam int TW  = $clog2(C1_TILES > C2_TILES ? C1_TILES : C2_TILES);
  localparam int CHW = $clog2(C1_CH > C2_CH ? C1_CH : C2_CH);
  localparam int AW2 = ADDR_W + 2;

  typedef enum logic [1:0] {IDLE, WR_C1, WR_C2, HOLD} fsm_t;

  fsm_t              fsm_q, fsm_d;
  logic              c2_q, c2_d;
  logic [TW-1:0]     col_q, col_d, row_q, row_d;
  logic [CHW-1:0]    ch_q, ch_d;
  logic              wen_a_q, wen_a_d, wen_b_q, wen_b_d;
  logic [3:0]        mask_a_q, mask_a_d, mask_b_q, mask_b_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [31:0]       wdata0_q, wdata0_d, wdata1_q, wdata1_d;
  logic [31:0]       wdata2_q, wdata2_d, wdata3_q, wdata3_d;
  logic              done_q, done_d;

  logic [3:0]        act_code;
  logic [TW-1:0]     tiles_m1;
  logic [CHW-1:0]    ch_m1;
  logic [AW2-1:0]    tiles;
  logic              in_wr, accept, last;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        mask;

  always_comb begin
    act_code = c2_q ? 4'd4 : 4'd3;
    tiles_m1 = c2_q ? TW'(C2_TILES - 1) : TW'(C1_TILES - 1);
    ch_m1    = c2_q ? CHW'(C2_CH - 1) : CHW'(C1_CH - 1);
    tiles    = c2_q ? AW2'(C2_TILES) : AW2'(C1_TILES);
    in_wr    = (fsm_q == WR_C1) || (fsm_q == WR_C2);
    accept   = in_wr && conv_valid && (state == act_code);
    last     = (ch_q == ch_m1) && (row_q == tiles_m1) && (col_q == tiles_m1);
    // Channels sharing a word occupy its four byte lanes; every 4 channels start a new map plane.
    addr     = ADDR_W'(AW2'(ch_q >> 2) * tiles * tiles + AW2'(row_q) * tiles + AW2'(col_q));
    mask     = ~(4'b1000 >> ch_q[1:0]);

    fsm_d    = fsm_q;
    c2_d     = c2_q;
    col_d    = col_q;
    row_d    = row_q;
    ch_d     = ch_q;
    wen_a_d  = 1'b1;
    wen_b_d  = 1'b1;
    mask_a_d = 4'hF;
    mask_b_d = 4'hF;
    addr_a_d = '0;
    addr_b_d = '0;
    wdata0_d = '0;
    wdata1_d = '0;
    wdata2_d = '0;
    wdata3_d = '0;
    done_d   = 1'b0;

    case (fsm_q)
      IDLE: begin
        col_d = '0;
        row_d = '0;
        ch_d  = '0;
        if (state == 4'd3) begin
          fsm_d = WR_C1;
          c2_d  = 1'b0;
        end else if (state == 4'd4) begin
          fsm_d = WR_C2;
          c2_d  = 1'b1;
        end
      end
      WR_C1, WR_C2: begin
        if (state != act_code) begin
          fsm_d = IDLE;
          col_d = '0;
          row_d = '0;
          ch_d  = '0;
        end else if (accept) begin
          if (last) begin
            fsm_d = HOLD;
          end else if (col_q != tiles_m1) begin
            col_d = col_q + 1'b1;
          end else begin
            col_d = '0;
            if (row_q != tiles_m1) begin
              row_d = row_q + 1'b1;
            end else begin
              row_d = '0;
              ch_d  = ch_q + 1'b1;
            end
          end
        end
      end
      default: begin
        if (!c2_q && state == 4'd4) begin
          fsm_d = WR_C2;
          c2_d  = 1'b1;
          col_d = '0;
          row_d = '0;
          ch_d  = '0;
        end else if (state != act_code) begin
          fsm_d = IDLE;
        end
      end
    endcase

    if (accept) begin
      if (c2_q) begin
        wen_a_d  = 1'b0;
        mask_a_d = mask;
        addr_a_d = addr;
      end else begin
        wen_b_d  = 1'b0;
        mask_b_d = mask;
        addr_b_d = addr;
      end
      wdata0_d = {4{conv_data0}};
      wdata1_d = {4{conv_data1}};
      wdata2_d = {4{conv_data2}};
      wdata3_d = {4{conv_data3}};
      done_d   = last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= IDLE;
      c2_q     <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      ch_q     <= '0;
      wen_a_q  <= 1'b1;
      wen_b_q  <= 1'b1;
      mask_a_q <= 4'hF;
      mask_b_q <= 4'hF;
      addr_a_q <= '0;
      addr_b_q <= '0;
      wdata0_q <= '0;
      wdata1_q <= '0;
      wdata2_q <= '0;
      wdata3_q <= '0;
      done_q   <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      c2_q     <= c2_d;
      col_q    <= col_d;
      row_q    <= row_d;
      ch_q     <= ch_d;
      wen_a_q  <= wen_a_d;
      wen_b_q  <= wen_b_d;
      mask_a_q <= mask_a_d;
      mask_b_q <= mask_b_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      wdata0_q <= wdata0_d;
      wdata1_q <= wdata1_d;
      wdata2_q <= wdata2_d;
      wdata3_q <= wdata3_d;
      done_q   <= done_d;
    end
  end

  assign sram_wen_a      = wen_a_q;
  assign sram_wen_b      = wen_b_q;
  assign sram_wordmask_a = mask_a_q;
  assign sram_wordmask_b = mask_b_q;
  assign sram_waddr_a    = addr_a_q;
  assign sram_waddr_b    = addr_b_q;
  assign sram_wdata0     = wdata0_q;
  assign sram_wdata1     = wdata1_q;
  assign sram_wdata2     = wdata2_q;
  assign sram_wdata3     = wdata3_q;
  assign layer_done      = done_q;

endmodule
